hs32_bus_arb: RTL and testbench

HS32_BUS_ARB -- requirements
Module: hs32_bus_arb

---
 rtl/hs32_bus_arb.sv | 164 ++++++++++++++++
 tb/tb_hs32_bus_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hs32_bus_arb.sv
// Three-channel arbiter for a single 32-bit handshake bus: fixed priority ch0>ch1>ch2
// with starvation promotion for ch1/ch2 and a per-transaction ready timeout.
module hs32_bus_arb #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] addr,
    output logic        rw,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        valid,
    input  logic        ready,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] addr2,
    input  logic [31:0] dtw0,
    input  logic [31:0] dtw1,
    input  logic [31:0] dtw2,
    input  logic        rw0,
    input  logic        rw1,
    input  logic        rw2,
    input  logic        req0,
    input  logic        req1,
    input  logic        req2,
    output logic        rdy0,
    output logic        rdy1,
    output logic        rdy2,
    output logic [31:0] dtr0,
    output logic [31:0] dtr1,
    output logic [31:0] dtr2,
    output logic        err
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic        rw_q, rw_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [2:0]  rdy_q, rdy_d;
    logic        err_q, err_d;
    logic [31:0] dtr_q [3];
    logic [31:0] dtr_d [3];
    logic [3:0]  wait_q [1:2];

    logic [31:0] ch_addr [3];
    logic [31:0] ch_dtw  [3];
    logic [2:0]  ch_rw;
    logic [2:0]  ch_req;
    logic [1:0]  sel;
    logic        grant_evt;

    assign ch_addr = '{addr0, addr1, addr2};
    assign ch_dtw  = '{dtw0, dtw1, dtw2};
    assign ch_rw   = {rw2, rw1, rw0};
    assign ch_req  = {req2, req1, req0};

    assign grant_evt = (state_q == IDLE) && (|ch_req);

    // A starved channel outranks ch0; ch1 wins when both are starved.
    always_comb begin
        sel = 2'd2;
        if (req1 && wait_q[1] == LIMIT)      sel = 2'd1;
        else if (req2 && wait_q[2] == LIMIT) sel = 2'd2;
        else if (req0)                       sel = 2'd0;
        else if (req1)                       sel = 2'd1;
    end

    generate
        for (genvar gi = 1; gi <= 2; gi++) begin : g_wait
            always_ff @(posedge clk) begin
                if (reset || !ch_req[gi]) begin
                    wait_q[gi] <= '0;
                end else if (grant_evt) begin
                    if (sel == 2'(gi))           wait_q[gi] <= '0;
                    else if (wait_q[gi] != LIMIT) wait_q[gi] <= wait_q[gi] + 4'd1;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rw_d    = rw_q;
        tmo_d   = tmo_q;
        rdy_d   = '0;
        err_d   = 1'b0;
        for (int i = 0; i < 3; i++) dtr_d[i] = dtr_q[i];

        case (state_q)
            IDLE: begin
                if (|ch_req) begin
                    state_d = BUSY;
                    gnt_d   = sel;
                    addr_d  = ch_addr[sel];
                    dout_d  = ch_dtw[sel];
                    rw_d    = ch_rw[sel];
                    tmo_d   = '0;
                end
            end
            BUSY: begin
                // ready takes precedence over a timeout expiring on the same edge
                if (ready || tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    err_d   = !ready;
                    for (int i = 0; i < 3; i++) begin
                        if (gnt_q == 2'(i)) begin
                            rdy_d[i] = 1'b1;
                            if (!rw_q) dtr_d[i] = ready ? din : 32'd0;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            rw_q    <= 1'b0;
            tmo_q   <= '0;
            rdy_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 3; i++) dtr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rw_q    <= rw_d;
            tmo_q   <= tmo_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            for (int i = 0; i < 3; i++) dtr_q[i] <= dtr_d[i];
        end
    end

    assign valid = (state_q == BUSY);
    assign addr  = addr_q;
    assign dout  = dout_q;
    assign rw    = rw_q;
    assign err   = err_q;
    assign rdy0  = rdy_q[0];
    assign rdy1  = rdy_q[1];
    assign rdy2  = rdy_q[2];
    assign dtr0  = dtr_q[0];
    assign dtr1  = dtr_q[1];
    assign dtr2  = dtr_q[2];
endmodule

// File: tb/tb_hs32_bus_arb.sv
// Directed bench for hs32_bus_arb: table of single transactions plus hand-written
// contention, timeout, ready/timeout boundary and mid-transaction reset sequences.
module tb_hs32_bus_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, din, dout;
    logic        rw, valid, ready, err;
    logic [31:0] addr0, addr1, addr2, dtw0, dtw1, dtw2;
    logic        rw0, rw1, rw2, req0, req1, req2;
    logic        rdy0, rdy1, rdy2;
    logic [31:0] dtr0, dtr1, dtr2;

    int checks   = 0;
    int failures = 0;

    hs32_bus_arb #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .addr(addr), .rw(rw), .din(din), .dout(dout), .valid(valid), .ready(ready),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .dtw0(dtw0), .dtw1(dtw1), .dtw2(dtw2),
        .rw0(rw0), .rw1(rw1), .rw2(rw2),
        .req0(req0), .req1(req1), .req2(req2),
        .rdy0(rdy0), .rdy1(rdy1), .rdy2(rdy2),
        .dtr0(dtr0), .dtr1(dtr1), .dtr2(dtr2),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic        rw;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          dly;
        logic [31:0] exp_dtr;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] rdy_all();
        return {rdy2, rdy1, rdy0};
    endfunction

    function automatic logic [31:0] dtr_of(input int ch);
        case (ch)
            0:       return dtr0;
            1:       return dtr1;
            default: return dtr2;
        endcase
    endfunction

    task automatic set_ch(input int ch, input logic rq, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        case (ch)
            0:       begin req0 = rq; rw0 = w; addr0 = a; dtw0 = d; end
            1:       begin req1 = rq; rw1 = w; addr1 = a; dtw1 = d; end
            default: begin req2 = rq; rw2 = w; addr2 = a; dtw2 = d; end
        endcase
    endtask

    task automatic do_txn(input vec_t v);
        set_ch(v.ch, 1'b1, v.rw, v.adr, v.wdat);
        step();
        chk("txn_valid", 32'(valid), 32'd1);
        chk("txn_addr", addr, v.adr);
        chk("txn_rw", 32'(rw), 32'(v.rw));
        chk("txn_dout", dout, v.wdat);
        for (int i = 0; i < v.dly; i++) begin
            step();
            chk("txn_hold_valid", 32'(valid), 32'd1);
            chk("txn_hold_addr", addr, v.adr);
            chk("txn_no_rdy", 32'(rdy_all()), 32'd0);
        end
        ready = 1'b1;
        din   = v.rdat;
        step();
        ready = 1'b0;
        set_ch(v.ch, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("txn_rdy", 32'(rdy_all()), 32'(3'b001 << v.ch));
        chk("txn_err", 32'(err), 32'd0);
        chk("txn_valid_low", 32'(valid), 32'd0);
        chk("txn_dtr", dtr_of(v.ch), v.exp_dtr);
        $display("txn ch%0d rw=%0b addr=%h dtr=%h", v.ch, v.rw, v.adr, dtr_of(v.ch));
        step();
        chk("txn_rdy_pulse", 32'(rdy_all()), 32'd0);
    endtask

    int exp_gnt [10] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 1};

    initial begin
        int n;
        vecs[0] = '{1, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
        vecs[1] = '{0, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'hAAAA_AAAA, 1, 32'h0};
        vecs[2] = '{2, 1'b0, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 2, 32'hCAFE_F00D};
        vecs[3] = '{0, 1'b0, 32'h0000_0400, 32'h0,         32'h0123_4567, 0, 32'h0123_4567};
        vecs[4] = '{0, 1'b1, 32'h0000_0404, 32'hFFFF_0000, 32'h5555_5555, 3, 32'h0123_4567};
        vecs[5] = '{1, 1'b1, 32'h0000_0104, 32'h0BAD_C0DE, 32'h7777_7777, 0, 32'hDEAD_BEEF};
        vecs[6] = '{2, 1'b0, 32'h0000_0308, 32'h0,         32'h1357_9BDF, 1, 32'h1357_9BDF};

        reset = 1'b1; ready = 1'b0; din = '0;
        for (int c = 0; c < 3; c++) set_ch(c, 1'b0, 1'b0, 32'd0, 32'd0);
        step(); step();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_rdy", 32'(rdy_all()), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dtr1", dtr1, 32'd0);
        reset = 1'b0;
        step();

        // ready must be ignored while idle
        ready = 1'b1; din = 32'hFFFF_FFFF;
        step();
        chk("idle_ready_valid", 32'(valid), 32'd0);
        chk("idle_ready_rdy", 32'(rdy_all()), 32'd0);
        ready = 1'b0;
        step();

        for (int i = 0; i < 7; i++) do_txn(vecs[i]);

        // Contention: all three channels held, reads, each channel a distinct address
        for (int c = 0; c < 3; c++) set_ch(c, 1'b1, 1'b0, 32'h1000 + 32'(c), 32'd0);
        for (int g = 0; g < 10; g++) begin
            n = 0;
            while (!valid && n < 4) begin step(); n++; end
            chk("cont_valid", 32'(valid), 32'd1);
            chk("cont_grant_addr", addr, 32'h1000 + 32'(exp_gnt[g]));
            ready = 1'b1; din = 32'(g);
            step();
            ready = 1'b0;
            chk("cont_rdy", 32'(rdy_all()), 32'(3'b001 << exp_gnt[g]));
            $display("txn contention grant %0d addr=%h rdy=%b", g, addr, rdy_all());
        end
        for (int c = 0; c < 3; c++) set_ch(c, 1'b0, 1'b0, 32'd0, 32'd0);
        step(); step();

        // Timeout on a ch2 read: abort after 255 BUSY cycles
        set_ch(2, 1'b1, 1'b0, 32'h0000_0500, 32'd0);
        step();
        chk("tmo_valid", 32'(valid), 32'd1);
        n = 0;
        while (!rdy2 && n < 300) begin step(); n++; end
        set_ch(2, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("tmo_cycles", 32'(n), 32'd255);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_dtr2", dtr2, 32'd0);
        chk("tmo_valid_low", 32'(valid), 32'd0);
        $display("txn timeout ch2 cycles=%0d err=%0b dtr2=%h", n, err, dtr2);
        step();
        chk("tmo_err_pulse", 32'(err), 32'd0);

        // ready arriving on the same edge the timeout would expire
        set_ch(0, 1'b1, 1'b0, 32'h0000_0600, 32'd0);
        step();
        repeat (254) step();
        chk("bnd_valid", 32'(valid), 32'd1);
        chk("bnd_no_rdy", 32'(rdy_all()), 32'd0);
        ready = 1'b1; din = 32'hA5A5_5A5A;
        step();
        ready = 1'b0;
        set_ch(0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("bnd_rdy0", 32'(rdy0), 32'd1);
        chk("bnd_err", 32'(err), 32'd0);
        chk("bnd_dtr0", dtr0, 32'hA5A5_5A5A);
        $display("txn boundary ch0 rdy0=%0b err=%0b dtr0=%h", rdy0, err, dtr0);
        step();

        // Reset during BUSY: abort silently
        set_ch(1, 1'b1, 1'b1, 32'h0000_0700, 32'h8765_4321);
        step();
        chk("rbusy_valid", 32'(valid), 32'd1);
        reset = 1'b1;
        step();
        chk("rbusy_valid_low", 32'(valid), 32'd0);
        chk("rbusy_rdy", 32'(rdy_all()), 32'd0);
        chk("rbusy_addr", addr, 32'd0);
        chk("rbusy_dout", dout, 32'd0);
        chk("rbusy_rw", 32'(rw), 32'd0);
        chk("rbusy_dtr0", dtr0, 32'd0);
        chk("rbusy_dtr2", dtr2, 32'd0);
        reset = 1'b0;
        set_ch(1, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("rbusy_after_rdy", 32'(rdy_all()), 32'd0);
        chk("rbusy_after_valid", 32'(valid), 32'd0);
        $display("txn reset-mid-busy valid=%0b rdy=%b", valid, rdy_all());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
